// File: rtl/proc_pkg.sv
// Shared definitions for the single-cycle WISC-subset core: opcodes, R-type
// function codes, the ALU operation set and instruction field helpers.
package proc_pkg;

    localparam int DW = 16;

    // Primary opcodes, instr[15:11]
    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_RTYPE = 5'b11011;

    // R-type function codes, instr[1:0]
    localparam logic [1:0] FN_ADD  = 2'b00;
    localparam logic [1:0] FN_SUB  = 2'b01;
    localparam logic [1:0] FN_XOR  = 2'b10;
    localparam logic [1:0] FN_ANDN = 2'b11;

    // ALU_SUB computes b - a so that SUBI (imm - Rs) and SUB (Rt - Rs) share it.
    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_ANDN,
        ALU_PASSB,
        ALU_SLBI
    } alu_op_t;

    // Instruction field slices
    function automatic logic [4:0] f_op(input logic [DW-1:0] i);
        return i[15:11];
    endfunction

    function automatic logic [2:0] f_rs(input logic [DW-1:0] i);
        return i[10:8];
    endfunction

    function automatic logic [2:0] f_rt(input logic [DW-1:0] i);
        return i[7:5];
    endfunction

    function automatic logic [2:0] f_rd(input logic [DW-1:0] i);
        return i[4:2];
    endfunction

    function automatic logic [1:0] f_func(input logic [DW-1:0] i);
        return i[1:0];
    endfunction

    // Immediate extension helpers
    function automatic logic [DW-1:0] sext5(input logic [DW-1:0] i);
        return {{11{i[4]}}, i[4:0]};
    endfunction

    function automatic logic [DW-1:0] zext5(input logic [DW-1:0] i);
        return {11'b0, i[4:0]};
    endfunction

    function automatic logic [DW-1:0] sext8(input logic [DW-1:0] i);
        return {{8{i[7]}}, i[7:0]};
    endfunction

    function automatic logic [DW-1:0] zext8(input logic [DW-1:0] i);
        return {8'b0, i[7:0]};
    endfunction

    function automatic logic [DW-1:0] sext11(input logic [DW-1:0] i);
        return {{5{i[10]}}, i[10:0]};
    endfunction

    // 16-bit two's complement ALU; carries and overflow are simply dropped.
    function automatic logic [DW-1:0] alu_eval(input alu_op_t op,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [DW-1:0] y;
        case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = b - a;
            ALU_XOR:   y = a ^ b;
            ALU_ANDN:  y = a & ~b;
            ALU_PASSB: y = b;
            ALU_SLBI:  y = {a[7:0], b[7:0]};
            default:   y = '0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/proc_regfile.sv
// 8 x 16 register file: two asynchronous read ports, one synchronous write
// port. Synchronous reset clears every register and wins over a write.
module proc_regfile
    import proc_pkg::*;
(
    input  logic          clk,
    input  logic          srst,
    input  logic [2:0]    ra_a,
    input  logic [2:0]    ra_b,
    input  logic          we,
    input  logic [2:0]    wa,
    input  logic [DW-1:0] wd,
    output logic [DW-1:0] rd_a,
    output logic [DW-1:0] rd_b
);

    logic [DW-1:0] rf_reg [8];
    logic [7:0]    wr_sel;

    // One-hot write select, one decoder line per register
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_wsel
            assign wr_sel[gi] = we && (wa == 3'(gi));
        end
    endgenerate

    // Register storage: reset clears all, otherwise the selected entry loads wd
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < 8; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_sel[i]) begin
                    rf_reg[i] <= wd;
                end
            end
        end
    end

    // Reads see the value before this cycle's write; no bypass is needed
    assign rd_a = rf_reg[ra_a];
    assign rd_b = rf_reg[ra_b];

endmodule

// File: rtl/single_cycle_proc.sv
// Single-cycle 16-bit load/store core: fetch, decode, execute and retire one
// instruction per clock. Only observable port is err (illegal opcode).
module single_cycle_proc
    import proc_pkg::*;
#(
    parameter string IMEM_FILE = "imem.hex",
    parameter int    MEM_WORDS = 256
) (
    input  logic clk,
    input  logic rst,
    output logic err
);

    localparam int AW = $clog2(MEM_WORDS);

    // The instruction image is preloaded by whatever loader owns IMEM_FILE;
    // the core itself only ever reads imem.
    generate
        if (IMEM_FILE == "") begin : g_no_image
        end
    endgenerate

    logic [DW-1:0] imem [MEM_WORDS];
    logic [DW-1:0] dmem [MEM_WORDS];

    logic [DW-1:0] pc;
    logic [DW-1:0] pc_next;
    logic [DW-1:0] pc_inc;
    logic [DW-1:0] pc_br;
    logic [DW-1:0] instr;
    logic          halted_reg;

    logic [4:0]    op;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;

    alu_op_t       alu_op;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_y;
    logic [DW-1:0] br_off;
    logic          wr_dec;
    logic          mem_we_dec;
    logic          wd_from_mem;
    logic          take_br;
    logic          is_halt;
    logic          illegal;
    logic          commit;
    logic          mem_we;
    logic [DW-1:0] mem_rd;

    logic [2:0]    rf_ws;
    logic [DW-1:0] rf_wd;
    logic          rf_we;

    // Combinational fetch, word-indexed by the byte pc
    assign instr = imem[pc[AW:1]];
    assign op    = f_op(instr);

    proc_regfile u_rf (
        .clk  (clk),
        .srst (rst),
        .ra_a (f_rs(instr)),
        .ra_b (f_rt(instr)),
        .we   (rf_we),
        .wa   (rf_ws),
        .wd   (rf_wd),
        .rd_a (rs_val),
        .rd_b (rt_val)
    );

    // Decode: ALU operation, operand B, destination and control strobes
    always_comb begin
        alu_op      = ALU_ADD;
        alu_b       = '0;
        rf_ws       = f_rt(instr);
        wr_dec      = 1'b0;
        mem_we_dec  = 1'b0;
        wd_from_mem = 1'b0;
        take_br     = 1'b0;
        br_off      = sext8(instr);
        is_halt     = 1'b0;
        illegal     = 1'b0;
        case (op)
            OP_HALT: is_halt = 1'b1;
            OP_NOP:  ;
            OP_ADDI: begin
                alu_op = ALU_ADD;
                alu_b  = sext5(instr);
                wr_dec = 1'b1;
            end
            OP_SUBI: begin
                alu_op = ALU_SUB;
                alu_b  = sext5(instr);
                wr_dec = 1'b1;
            end
            OP_XORI: begin
                alu_op = ALU_XOR;
                alu_b  = zext5(instr);
                wr_dec = 1'b1;
            end
            OP_ANDNI: begin
                alu_op = ALU_ANDN;
                alu_b  = zext5(instr);
                wr_dec = 1'b1;
            end
            OP_LBI: begin
                alu_op = ALU_PASSB;
                alu_b  = sext8(instr);
                rf_ws  = f_rs(instr);
                wr_dec = 1'b1;
            end
            OP_SLBI: begin
                alu_op = ALU_SLBI;
                alu_b  = zext8(instr);
                rf_ws  = f_rs(instr);
                wr_dec = 1'b1;
            end
            OP_RTYPE: begin
                alu_b  = rt_val;
                rf_ws  = f_rd(instr);
                wr_dec = 1'b1;
                case (f_func(instr))
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_ANDN: alu_op = ALU_ANDN;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_ST: begin
                alu_b      = sext5(instr);
                mem_we_dec = 1'b1;
            end
            OP_LD: begin
                alu_b       = sext5(instr);
                wr_dec      = 1'b1;
                wd_from_mem = 1'b1;
            end
            OP_BEQZ: take_br = (rs_val == '0);
            OP_BNEZ: take_br = (rs_val != '0);
            OP_J: begin
                take_br = 1'b1;
                br_off  = sext11(instr);
            end
            default: illegal = 1'b1;
        endcase
    end

    // Execute and data memory read
    assign alu_y  = alu_eval(alu_op, rs_val, alu_b);
    assign mem_rd = dmem[alu_y[AW:1]];
    assign rf_wd  = wd_from_mem ? mem_rd : alu_y;

    // Retire gating: illegal, halting and reset cycles change no state
    assign commit = !illegal && !is_halt && !halted_reg && !rst;
    assign rf_we  = wr_dec && commit;
    assign mem_we = mem_we_dec && commit;
    assign err    = illegal && !rst;

    // Next pc: sequential, branch/jump target, or hold
    assign pc_inc = pc + 16'd2;
    assign pc_br  = pc_inc + br_off;

    always_comb begin
        pc_next = pc;
        if (commit) begin
            pc_next = take_br ? pc_br : pc_inc;
        end
    end

    // Program counter and sticky halt flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= '0;
            halted_reg <= 1'b0;
        end else begin
            pc <= pc_next;
            if (is_halt && !illegal) begin
                halted_reg <= 1'b1;
            end
        end
    end

    // Data memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            dmem[alu_y[AW:1]] <= rt_val;
        end
    end

endmodule

// File: tb/tb_single_cycle_proc.sv
// Directed program test for single_cycle_proc: loads a small instruction
// image, steps it one instruction per clock and compares architectural state
// against hand-computed values.
module tb_single_cycle_proc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] prog [24] = '{
        16'hc010, 16'hc101, 16'hc2ff, 16'h9234,   //  0: lbi r0; lbi r1; lbi r2; slbi r2
        16'h427f, 16'hd911, 16'h8022, 16'h88a2,   //  8: addi r3; sub r4; st r1; ld r5
        16'h6604, 16'hc755, 16'hc7aa, 16'h49e5,   // 16: beqz r6,+4; skipped x2; subi r7
        16'h52df, 16'h5b63, 16'hda36, 16'hda13,   // 24: xori r6; andni r3; xor r5; andn r4
        16'hd820, 16'h6f02, 16'hc7bb, 16'h6104,   // 32: add r0; bnez r7,+2; skipped; beqz r1
        16'h2002, 16'hc7cc, 16'h0800, 16'hf800    // 40: j +2; skipped; nop; illegal
    };

    single_cycle_proc #(
        .IMEM_FILE ("imem.hex"),
        .MEM_WORDS (256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .err (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 24; i++) begin
            dut.imem[i] = prog[i];
        end

        // Reset held two cycles
        rst = 1'b1;
        step();
        step();
        chk("reset pc", dut.pc, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("reset r%0d", i), dut.u_rf.rf_reg[i], 16'h0000);
        end
        chk("reset err", 16'(err), 16'h0000);
        rst = 1'b0;

        // lbi r0,0x10 ; lbi r1,0x01
        step();
        chk("lbi r0", dut.u_rf.rf_reg[0], 16'h0010);
        chk("pc after 1", dut.pc, 16'h0002);
        chk("rf_ws", 16'(dut.rf_ws), 16'h0001);
        chk("rf_wd", dut.rf_wd, 16'h0001);
        chk("rf_we", 16'(dut.rf_we), 16'h0001);
        step();
        chk("lbi r1", dut.u_rf.rf_reg[1], 16'h0001);

        // lbi r2,0xFF ; slbi r2,0x34
        step();
        chk("lbi r2", dut.u_rf.rf_reg[2], 16'hffff);
        step();
        chk("slbi r2", dut.u_rf.rf_reg[2], 16'hff34);

        // addi r3,r2,-1 ; sub r4 = r0 - r1
        step();
        chk("addi r3", dut.u_rf.rf_reg[3], 16'hff33);
        step();
        chk("sub r4", dut.u_rf.rf_reg[4], 16'h000f);

        // st r1 -> [r0+2] ; ld r5 <- [r0+2]
        step();
        chk("st dmem", dut.dmem[9], 16'h0001);
        step();
        chk("ld r5", dut.u_rf.rf_reg[5], 16'h0001);
        chk("pc before beqz", dut.pc, 16'h0010);

        // beqz r6,+4 taken: pc advances by 6
        step();
        chk("beqz taken pc", dut.pc, 16'h0016);

        // Immediate and R-type ALU forms
        step();
        chk("subi r7", dut.u_rf.rf_reg[7], 16'h0004);
        step();
        chk("xori r6", dut.u_rf.rf_reg[6], 16'hff2b);
        step();
        chk("andni r3", dut.u_rf.rf_reg[3], 16'hff30);
        step();
        chk("xor r5", dut.u_rf.rf_reg[5], 16'hff35);
        step();
        chk("andn r4", dut.u_rf.rf_reg[4], 16'hff24);
        step();
        chk("add r0", dut.u_rf.rf_reg[0], 16'h0011);
        chk("pc 34", dut.pc, 16'h0022);

        // Control flow: bnez taken, beqz not taken, jump
        step();
        chk("bnez taken pc", dut.pc, 16'h0026);
        step();
        chk("beqz fall pc", dut.pc, 16'h0028);
        step();
        chk("j pc", dut.pc, 16'h002c);
        step();
        chk("nop pc", dut.pc, 16'h002e);
        chk("skipped r7", dut.u_rf.rf_reg[7], 16'h0004);

        // Illegal opcode: err same cycle, no state change
        chk("illegal err", 16'(err), 16'h0001);
        rst = 1'b1;
        #1;
        chk("err masked by rst", 16'(err), 16'h0000);
        rst = 1'b0;
        #1;
        step();
        chk("illegal pc hold", dut.pc, 16'h002e);
        chk("illegal r0 hold", dut.u_rf.rf_reg[0], 16'h0011);
        chk("illegal err held", 16'(err), 16'h0001);

        // Replace with HALT: pc stays put for 10 cycles
        dut.imem[23] = 16'h0000;
        #1;
        chk("halt err", 16'(err), 16'h0000);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("halt pc c%0d", i), dut.pc, 16'h002e);
        end
        chk("halt r5 hold", dut.u_rf.rf_reg[5], 16'hff35);

        // Reset out of halt
        rst = 1'b1;
        step();
        chk("rst2 pc", dut.pc, 16'h0000);
        chk("rst2 r0", dut.u_rf.rf_reg[0], 16'h0000);
        chk("rst2 r3", dut.u_rf.rf_reg[3], 16'h0000);
        rst = 1'b0;
        step();
        chk("rerun r0", dut.u_rf.rf_reg[0], 16'h0010);
        chk("rerun pc", dut.pc, 16'h0002);

        // Reset mid-program overrides the lbi r1 of this cycle
        rst = 1'b1;
        step();
        chk("midrst pc", dut.pc, 16'h0000);
        chk("midrst r1", dut.u_rf.rf_reg[1], 16'h0000);
        chk("midrst r0", dut.u_rf.rf_reg[0], 16'h0000);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
